riscv_qnt_packer: RTL



---
 rtl/riscv_defines.sv | 18 +
 rtl/riscv_qnt_pack_outreg.sv | 45 ++++
 rtl/riscv_qnt_packer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
// Shared decode constants and types for the quantized-result packer.
// VEC_MODE2 / VEC_MODE4 select the quantized pixel width on vecmode_i.
package riscv_defines;

  localparam logic [2:0] VEC_MODE2 = 3'b101;
  localparam logic [2:0] VEC_MODE4 = 3'b110;

  // Field width per accepted result in the packed word
  localparam int QNT_PACK_F2 = 4;
  localparam int QNT_PACK_F4 = 8;

  typedef enum logic [1:0] {
    QNT_EMPTY = 2'd0,
    QNT_FILL  = 2'd1,
    QNT_HOLD  = 2'd2
  } qnt_pack_state_e;

endpackage

// File: rtl/riscv_qnt_pack_outreg.sv
// Single-entry output register with valid/ready handshake.
// Valid/ready: a word moves out on a cycle where valid_o & ready_i are both
// high; valid_o never drops and data_o/count_o never change until then.
// can_load_o tells the producer a new word may be written this cycle.
module riscv_qnt_pack_outreg #(
  parameter int W  = 32,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [W-1:0]  data_i,
  input  logic [CW-1:0] count_i,
  output logic          can_load_o,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o,
  input  logic          ready_i
);

  logic          valid_q;
  logic [W-1:0]  data_q;
  logic [CW-1:0] count_q;

  assign can_load_o = !valid_q | ready_i;
  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign count_o    = count_q;

  // Load a new word (possibly in the same cycle the old one is taken)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      count_q <= count_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_qnt_packer.sv
// Packs 2-bit or 4-bit quantized pixel pairs into 32-bit words for the store
// path. Optional performance counters are enabled with QNT_PACKER_PERF_EN.
// Valid/ready: an input is taken when in_valid_i & in_ready_o; a word is
// taken when out_valid_o & out_ready_i, and is held stable until then.
module riscv_qnt_packer
  import riscv_defines::*;
#(
  parameter int MSB_FIRST = 0,
  parameter int WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        vecmode_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  input  logic              flush_i,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic [4:0]        out_count_o,
  input  logic              out_ready_i,
  output logic              busy_o
`ifdef QNT_PACKER_PERF_EN
  ,
  output logic [31:0]       words_o,
  output logic [31:0]       stall_cycles_o
`endif
);

  qnt_pack_state_e   state_q, state_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [3:0]        slot_q, slot_d;
  logic              mode_q, mode_d;   // 1: 2-bit pixels, 0: 4-bit pixels

  logic              mode_in, cur_mode, mismatch, in_ready, accept;
  logic [3:0]        n_slots, pos, slot_ins, close_slots;
  logic [4:0]        shamt;
  logic [WORD_W-1:0] field, acc_ins, close_data, load_data;
  logic [4:0]        load_cnt;
  logic              full, close, pending, load, can_load;

  // Slot insertion, word-close detection and next-state selection
  always_comb begin
    mode_in  = (vecmode_i == VEC_MODE2);
    cur_mode = (state_q == QNT_EMPTY) ? mode_in : mode_q;
    mismatch = (state_q == QNT_FILL) & in_valid_i & (mode_in != mode_q);
    in_ready = (state_q != QNT_HOLD) & !mismatch;
    accept   = in_valid_i & in_ready;

    n_slots  = cur_mode ? 4'd8 : 4'd4;
    pos      = (MSB_FIRST != 0) ? (n_slots - 4'd1 - slot_q) : slot_q;
    shamt    = cur_mode ? {pos[2:0], 2'b00} : {pos[1:0], 3'b000};
    field    = cur_mode ? {{(WORD_W-QNT_PACK_F2){1'b0}}, in_data_i[3:0]}
                        : {{(WORD_W-QNT_PACK_F4){1'b0}}, in_data_i};
    acc_ins  = acc_q | (field << shamt);
    slot_ins = slot_q + 4'd1;

    // A mode change mid-word closes the partial word like a flush
    full     = accept & (slot_ins == n_slots);
    close    = full | mismatch |
               (flush_i & (state_q != QNT_HOLD) & ((slot_q != 4'd0) | accept));

    close_data  = accept ? acc_ins : acc_q;
    close_slots = accept ? slot_ins : slot_q;

    pending   = close | (state_q == QNT_HOLD);
    load      = pending & can_load;
    load_data = (state_q == QNT_HOLD) ? acc_q : close_data;
    load_cnt  = (state_q == QNT_HOLD) ? {slot_q, 1'b0} : {close_slots, 1'b0};

    state_d = state_q;
    acc_d   = acc_q;
    slot_d  = slot_q;
    mode_d  = mode_q;
    if (accept && state_q == QNT_EMPTY) mode_d = mode_in;
    if (load) begin
      state_d = QNT_EMPTY;
      acc_d   = '0;
      slot_d  = 4'd0;
    end else if (close) begin
      state_d = QNT_HOLD;
      acc_d   = close_data;
      slot_d  = close_slots;
    end else if (accept) begin
      state_d = QNT_FILL;
      acc_d   = acc_ins;
      slot_d  = slot_ins;
    end
  end

  // Packer state machine and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= QNT_EMPTY;
      acc_q   <= '0;
      slot_q  <= 4'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      slot_q  <= slot_d;
      mode_q  <= mode_d;
    end
  end

  riscv_qnt_pack_outreg #(
    .W  (WORD_W),
    .CW (5)
  ) u_outreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .data_i     (load_data),
    .count_i    (load_cnt),
    .can_load_o (can_load),
    .valid_o    (out_valid_o),
    .data_o     (out_data_o),
    .count_o    (out_count_o),
    .ready_i    (out_ready_i)
  );

  assign in_ready_o = in_ready;
  assign busy_o     = (state_q != QNT_EMPTY) | out_valid_o;

`ifdef QNT_PACKER_PERF_EN
  logic [31:0] words_q, stall_q;

  // Count words taken and cycles where an input was refused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (out_valid_o & out_ready_i) words_q <= words_q + 32'd1;
      if (in_valid_i & !in_ready)    stall_q <= stall_q + 32'd1;
    end
  end

  assign words_o        = words_q;
  assign stall_cycles_o = stall_q;
`endif

endmodule
